// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
package mouse_pkg;

   localparam int PS2_DATA_BITS = 8;

   typedef enum logic [3:0] {
      IDLE      = 4'b0001,
      RX_DATA   = 4'b0010,
      RX_PARITY = 4'b0100,
      RX_STOP   = 4'b1000
   } rx_state_t;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_PARITY = 2'b01;
   localparam logic [1:0] ERR_STOP   = 2'b10;
   localparam logic [1:0] ERR_BOTH   = 2'b11;

endpackage

// File: rtl/mouse_receiver_if.sv
// Bundle between the PS/2 pins, the mouse master and the byte receiver.
interface mouse_receiver_if;
   import mouse_pkg::*;

   logic                     CLK_MOUSE_IN;
   logic                     DATA_MOUSE_IN;
   logic                     READ_ENABLE;
   logic [PS2_DATA_BITS-1:0] BYTE_READ;
   logic [1:0]               BYTE_ERROR_CODE;
   logic                     BYTE_READY;
   logic [3:0]               current_state;

   modport master (
      output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
      input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, current_state
   );

   modport slave (
      input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
      output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, current_state
   );

endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 clock, debounces it with a run-length filter
// and flags each filtered falling edge. Shared by receive and transmit paths.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic CLK,
   input  logic RESET,
   input  logic ps2_clk,
   output logic level,
   output logic fall
);

   logic       sync1_reg;
   logic       sync2_reg;
   logic       level_reg;
   logic       level_prev_reg;
   logic       fall_reg;
   logic [7:0] run_cnt_reg;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_reg      <= 1'b1;
         sync2_reg      <= 1'b1;
         level_reg      <= 1'b1;
         level_prev_reg <= 1'b1;
         fall_reg       <= 1'b0;
         run_cnt_reg    <= 8'd0;
      end else begin
         sync1_reg      <= ps2_clk;
         sync2_reg      <= sync1_reg;
         level_prev_reg <= level_reg;
         fall_reg       <= level_prev_reg & ~level_reg;
         // Any sample agreeing with the current level restarts the run.
         if (sync2_reg == level_reg) begin
            run_cnt_reg <= 8'd0;
         end else if (run_cnt_reg == 8'(FILTER_LEN - 1)) begin
            level_reg   <= sync2_reg;
            run_cnt_reg <= 8'd0;
         end else begin
            run_cnt_reg <= run_cnt_reg + 8'd1;
         end
      end
   end

   assign level = level_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host deframer: start, 8 data bits LSB first, odd parity,
// stop. Each frame ends in a one-cycle BYTE_READY with a 2-bit error code.
module mouse_receiver
   import mouse_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50_000
) (
   input  logic              CLK,
   input  logic              RESET,
   mouse_receiver_if.slave   bus
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic                     data_sync1_reg, data_sync2_reg;
   logic                     clk_level, clk_fall, fall;
   rx_state_t                state_reg, state_next;
   logic [2:0]               bit_cnt_reg, bit_cnt_next;
   logic [PS2_DATA_BITS-1:0] shift_reg, shift_next;
   logic                     parity_reg, parity_next;
   logic [TMO_W-1:0]         tmo_reg, tmo_next;
   logic [PS2_DATA_BITS-1:0] byte_reg, byte_next;
   logic [1:0]               err_reg, err_next;
   logic                     ready_reg, ready_next;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .CLK     (CLK),
      .RESET   (RESET),
      .ps2_clk (bus.CLK_MOUSE_IN),
      .level   (clk_level),
      .fall    (clk_fall)
   );

   // The edge pulse trails the level by a cycle; requiring the level to
   // still be low keeps the qualification explicit.
   assign fall = clk_fall & ~clk_level;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         data_sync1_reg <= 1'b1;
         data_sync2_reg <= 1'b1;
         state_reg      <= IDLE;
         bit_cnt_reg    <= 3'd0;
         shift_reg      <= '0;
         parity_reg     <= 1'b0;
         tmo_reg        <= '0;
         byte_reg       <= '0;
         err_reg        <= ERR_NONE;
         ready_reg      <= 1'b0;
      end else begin
         data_sync1_reg <= bus.DATA_MOUSE_IN;
         data_sync2_reg <= data_sync1_reg;
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
         parity_reg     <= parity_next;
         tmo_reg        <= tmo_next;
         byte_reg       <= byte_next;
         err_reg        <= err_next;
         ready_reg      <= ready_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      parity_next  = parity_reg;
      byte_next    = byte_reg;
      err_next     = err_reg;
      ready_next   = 1'b0;

      if (state_reg == IDLE || fall) tmo_next = '0;
      else                           tmo_next = tmo_reg + 1'b1;

      case (state_reg)
         IDLE: begin
            if (fall && bus.READ_ENABLE && !data_sync2_reg) begin
               state_next   = RX_DATA;
               bit_cnt_next = 3'd0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shift_next   = {data_sync2_reg, shift_reg[PS2_DATA_BITS-1:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'(PS2_DATA_BITS - 1)) state_next = RX_PARITY;
            end
         end
         RX_PARITY: begin
            if (fall) begin
               parity_next = data_sync2_reg;
               state_next  = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               state_next = IDLE;
               ready_next = 1'b1;
               byte_next  = shift_reg;
               err_next   = {~data_sync2_reg, ~(^{shift_reg, parity_reg})};
            end
         end
         default: state_next = IDLE;
      endcase

      // A fall in the terminal cycle keeps the frame alive.
      if (state_reg != IDLE && !fall && tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1))
         state_next = IDLE;

      // The master owns the line while READ_ENABLE is low; this beats a stop bit.
      if (state_reg != IDLE && !bus.READ_ENABLE) begin
         state_next = IDLE;
         ready_next = 1'b0;
         byte_next  = byte_reg;
         err_next   = err_reg;
      end
   end

   assign bus.BYTE_READ       = byte_reg;
   assign bus.BYTE_ERROR_CODE = err_reg;
   assign bus.BYTE_READY      = ready_reg;
   assign bus.current_state   = state_reg;

endmodule
